// File: rtl/decode_stage_pkg.sv
// Shared decode definitions for the ID/EX stage: opcodes, funct codes, ALU
// codes, immediate-extension modes and the registered control bundle.
package decode_stage_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned ALU_W   = 3;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [ALU_W-1:0] ALU_ADD  = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND  = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR   = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SLTU = 3'b111;

  localparam logic [REG_W-1:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {
    IMM_SIGN = 2'd0,
    IMM_ZERO = 2'd1,
    IMM_LUI  = 2'd2
  } imm_mode_e;

  typedef struct packed {
    logic             memtoreg;
    logic             memwrite;
    logic             isbranch;
    logic             alusrcbimm;
    logic             regwrite;
    logic             dojump;
    logic             link;
    logic             illegal;
    logic [REG_W-1:0] destreg;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [ALU_W-1:0] alucontrol;
    logic [31:0]      imm;
    logic [25:0]      jtarget;
  } bundle_t;

endpackage

// File: rtl/decode_stage_decode_comb.sv
// Purely combinational instruction decoder: instruction word to control
// bundle, plus which source registers the instruction actually reads.
module decode_comb
  import decode_stage_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output bundle_t            bundle,
  output logic               uses_rs,
  output logic               uses_rt
);

  logic [5:0] op;
  logic [5:0] funct;
  imm_mode_e  mode;

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  always_comb begin
    bundle            = '0;
    bundle.rs         = instr[25:21];
    bundle.rt         = instr[20:16];
    bundle.jtarget    = instr[25:0];
    bundle.destreg    = instr[20:16];
    bundle.alucontrol = ALU_ADD;
    mode              = IMM_SIGN;
    uses_rs           = 1'b1;
    uses_rt           = 1'b0;

    case (op)
      OP_RTYPE: begin
        uses_rt         = 1'b1;
        bundle.destreg  = instr[15:11];
        bundle.regwrite = 1'b1;
        case (funct)
          FN_ADDU: bundle.alucontrol = ALU_ADD;
          FN_SUBU: bundle.alucontrol = ALU_SUB;
          FN_AND:  bundle.alucontrol = ALU_AND;
          FN_OR:   bundle.alucontrol = ALU_OR;
          FN_SLTU: bundle.alucontrol = ALU_SLTU;
          default: bundle.illegal    = 1'b1;
        endcase
      end
      OP_LW: begin
        bundle.alusrcbimm = 1'b1;
        bundle.regwrite   = 1'b1;
        bundle.memtoreg   = 1'b1;
      end
      OP_SW: begin
        uses_rt           = 1'b1;
        bundle.alusrcbimm = 1'b1;
        bundle.memwrite   = 1'b1;
      end
      OP_BEQ: begin
        uses_rt           = 1'b1;
        bundle.isbranch   = 1'b1;
        bundle.alucontrol = ALU_SUB;
      end
      OP_ADDIU: begin
        bundle.alusrcbimm = 1'b1;
        bundle.regwrite   = 1'b1;
      end
      OP_ORI: begin
        bundle.alusrcbimm = 1'b1;
        bundle.regwrite   = 1'b1;
        bundle.alucontrol = ALU_OR;
        mode              = IMM_ZERO;
      end
      OP_LUI: begin
        // rs is architecturally $0, so or-ing the shifted immediate loads it
        uses_rs           = 1'b0;
        bundle.alusrcbimm = 1'b1;
        bundle.regwrite   = 1'b1;
        bundle.alucontrol = ALU_OR;
        mode              = IMM_LUI;
      end
      OP_J: begin
        uses_rs        = 1'b0;
        bundle.dojump  = 1'b1;
        bundle.destreg = '0;
      end
      OP_JAL: begin
        uses_rs         = 1'b0;
        bundle.dojump   = 1'b1;
        bundle.regwrite = 1'b1;
        bundle.link     = 1'b1;
        bundle.destreg  = REG_RA;
      end
      default: bundle.illegal = 1'b1;
    endcase

    // An undecodable instruction must never change architectural state
    if (bundle.illegal) begin
      bundle.regwrite = 1'b0;
      bundle.memwrite = 1'b0;
      bundle.isbranch = 1'b0;
      bundle.dojump   = 1'b0;
    end

    case (mode)
      IMM_ZERO: bundle.imm = {16'h0000, instr[15:0]};
      IMM_LUI:  bundle.imm = {instr[15:0], 16'h0000};
      default:  bundle.imm = {{16{instr[15]}}, instr[15:0]};
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// ID/EX pipeline stage: registered decode bundle with valid/ready handshake,
// load-use stalling, flush and a saturating stall counter.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned ALUCTRL_W = 3,
  parameter bit          HAZARD_EN = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_valid,
  input  logic [INSTR_W-1:0]   if_instr,
  input  logic [PC_W-1:0]      if_pc,
  output logic                 if_ready,
  input  logic                 flush,
  input  logic                 ex_ready,
  output logic                 ex_valid,
  output logic                 ex_memtoreg,
  output logic                 ex_memwrite,
  output logic                 ex_isbranch,
  output logic                 ex_alusrcbimm,
  output logic                 ex_regwrite,
  output logic                 ex_dojump,
  output logic                 ex_link,
  output logic [REG_W-1:0]     ex_destreg,
  output logic [REG_W-1:0]     ex_rs,
  output logic [REG_W-1:0]     ex_rt,
  output logic [31:0]          ex_imm,
  output logic [25:0]          ex_jtarget,
  output logic [PC_W-1:0]      ex_pc,
  output logic [ALUCTRL_W-1:0] ex_alucontrol,
  output logic                 ex_illegal,
  output logic [CNT_W-1:0]     stall_count
);

  bundle_t              dec;
  logic                 uses_rs;
  logic                 uses_rt;

  bundle_t              bundle_q, bundle_d;
  logic                 valid_q, valid_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 adv;
  logic                 hit;
  logic                 hz;

  decode_comb u_decode_comb (
    .instr   (if_instr),
    .bundle  (dec),
    .uses_rs (uses_rs),
    .uses_rt (uses_rt)
  );

  assign adv = ~valid_q | ex_ready;

  // Load in EX whose destination is read by the instruction now in ID
  assign hit = (uses_rs && (bundle_q.destreg == dec.rs)) ||
               (uses_rt && (bundle_q.destreg == dec.rt));
  assign hz  = HAZARD_EN && valid_q && bundle_q.memtoreg && if_valid &&
               (bundle_q.destreg != '0) && hit;

  // While reset is held the stage simply mirrors downstream readiness
  assign if_ready = reset ? ex_ready : ((adv & ~hz) | flush);

  always_comb begin
    bundle_d = bundle_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    if (flush) begin
      if (adv) begin
        bundle_d = '0;
        valid_d  = 1'b0;
        pc_d     = '0;
      end
    end else if (hz) begin
      if (adv) begin
        bundle_d = '0;
        valid_d  = 1'b0;
        pc_d     = '0;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else if (adv) begin
      if (if_valid) begin
        bundle_d = dec;
        valid_d  = 1'b1;
        pc_d     = if_pc;
      end else begin
        bundle_d = '0;
        valid_d  = 1'b0;
        pc_d     = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bundle_q <= '0;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      cnt_q    <= '0;
    end else begin
      bundle_q <= bundle_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_memtoreg   = bundle_q.memtoreg;
  assign ex_memwrite   = bundle_q.memwrite;
  assign ex_isbranch   = bundle_q.isbranch;
  assign ex_alusrcbimm = bundle_q.alusrcbimm;
  assign ex_regwrite   = bundle_q.regwrite;
  assign ex_dojump     = bundle_q.dojump;
  assign ex_link       = bundle_q.link;
  assign ex_destreg    = bundle_q.destreg;
  assign ex_rs         = bundle_q.rs;
  assign ex_rt         = bundle_q.rt;
  assign ex_imm        = bundle_q.imm;
  assign ex_jtarget    = bundle_q.jtarget;
  assign ex_pc         = pc_q;
  assign ex_alucontrol = ALUCTRL_W'(bundle_q.alucontrol);
  assign ex_illegal    = bundle_q.illegal;
  assign stall_count   = cnt_q;

endmodule
